// File: rtl/temp_bcd.sv
// Temperature magnitude to seven-digit packed BCD converter using a serial double-dabble.
// A conversion runs on reset release (INIT_CONV), on an input change, or on a start request.
module temp_bcd #(
  parameter bit INIT_CONV = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [24:0] temp_data,
  input  logic        sign,
  input  logic        start,
  output logic [27:0] bcd,
  output logic        sign_out,
  output logic        ovf,
  output logic        busy,
  output logic        bcd_valid
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  localparam logic [24:0] MAX_DEC = 25'd9999999;
  localparam logic [4:0]  LAST_ITER = 5'd24;

  logic [1:0]  state_q,    state_d;
  logic [25:0] snap_q,     snap_d;
  logic [27:0] acc_q,      acc_d;
  logic [24:0] bin_q,      bin_d;
  logic [4:0]  cnt_q,      cnt_d;
  logic        of_q,       of_d;
  logic        pend_q,     pend_d;
  logic [27:0] bcd_q,      bcd_d;
  logic        sign_out_q, sign_out_d;
  logic        ovf_q,      ovf_d;
  logic        valid_q,    valid_d;

  logic [27:0] acc_adj;
  logic        trigger;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 7; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The snapshot holds the last input that was converted; any difference re-triggers.
  assign trigger = start || ({sign, temp_data} != snap_q) || pend_q;

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    acc_d      = acc_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    of_d       = of_q;
    pend_d     = pend_q;
    bcd_d      = bcd_q;
    sign_out_d = sign_out_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          snap_d  = {sign, temp_data};
          acc_d   = 28'd0;
          bin_d   = temp_data;
          cnt_d   = 5'd0;
          of_d    = (temp_data > MAX_DEC);
          pend_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = {acc_adj[26:0], bin_q[24]};
        bin_d = {bin_q[23:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d      = of_q ? 28'h9999999 : acc_q;
        sign_out_d = snap_q[25];
        ovf_d      = of_q;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      snap_q     <= 26'd0;
      acc_q      <= 28'd0;
      bin_q      <= 25'd0;
      cnt_q      <= 5'd0;
      of_q       <= 1'b0;
      pend_q     <= INIT_CONV;
      bcd_q      <= 28'd0;
      sign_out_q <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      acc_q      <= acc_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      of_q       <= of_d;
      pend_q     <= pend_d;
      bcd_q      <= bcd_d;
      sign_out_q <= sign_out_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign bcd       = bcd_q;
  assign sign_out  = sign_out_q;
  assign ovf       = ovf_q;
  assign bcd_valid = valid_q;
  assign busy      = (state_q == SHIFT) || (state_q == DONE);

endmodule

// File: tb/tb_temp_bcd.sv
// Directed bench for temp_bcd: latency, values, overflow, retrigger, start and reset abort.
module tb_temp_bcd;

  logic        clk;
  logic        rst_n;
  logic [24:0] temp_data;
  logic        sign;
  logic        start;
  logic [27:0] bcd;
  logic        sign_out;
  logic        ovf;
  logic        busy;
  logic        bcd_valid;

  int total;
  int bad;

  temp_bcd #(.INIT_CONV(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .temp_data(temp_data),
    .sign     (sign),
    .start    (start),
    .bcd      (bcd),
    .sign_out (sign_out),
    .ovf      (ovf),
    .busy     (busy),
    .bcd_valid(bcd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns the number of falling edges until bcd_valid is seen, or -1 on timeout.
  task automatic wait_valid(input int max_cycles, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b1; temp_data = 25'd0; sign = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bcd, sign_out, ovf, busy, bcd_valid} !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got bcd=%h s=%b o=%b busy=%b v=%b want all 0",
               bcd, sign_out, ovf, busy, bcd_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL init_conv_busy: got %b want 1", busy);
    end
    wait_valid(40, lat);
    total++;
    if (lat != 26 || bcd !== 28'h0 || sign_out !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL init_conv_result: got lat=%0d bcd=%h s=%b o=%b want lat=26 bcd=0000000 s=0 o=0",
               lat, bcd, sign_out, ovf);
    end
  endtask

  task automatic test_convert(input logic [24:0] val, input logic sg,
                              input logic [27:0] exp_bcd, input logic exp_ovf);
    int lat;
    temp_data = val; sign = sg;
    wait_valid(40, lat);
    total++;
    if (lat != 27) begin
      bad++;
      $display("[TB] FAIL latency_%0d: got %0d want 27", val, lat);
    end
    total++;
    if (bcd !== exp_bcd || sign_out !== sg || ovf !== exp_ovf) begin
      bad++;
      $display("[TB] FAIL value_%0d: got bcd=%h s=%b o=%b want bcd=%h s=%b o=%b",
               val, bcd, sign_out, ovf, exp_bcd, sg, exp_ovf);
    end
    @(negedge clk);
    total++;
    if (bcd_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pulse_width_%0d: got v=%b busy=%b want v=0 busy=0", val, bcd_valid, busy);
    end
  endtask

  task automatic test_hold_quiet();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0 || bcd !== 28'h0101250 || sign_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hold_quiet: got pulses=%0d bcd=%h s=%b want pulses=0 bcd=0101250 s=1",
               pulses, bcd, sign_out);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    temp_data = 25'd625; sign = 1'b0;
    repeat (5) @(negedge clk);
    temp_data = 25'd1250;
    wait_valid(40, lat);
    total++;
    if (lat != 22 || bcd !== 28'h0000625) begin
      bad++;
      $display("[TB] FAIL b2b_first: got lat=%0d bcd=%h want lat=22 bcd=0000625", lat, bcd);
    end
    wait_valid(40, lat);
    total++;
    if (lat != 27 || bcd !== 28'h0001250) begin
      bad++;
      $display("[TB] FAIL b2b_second: got lat=%0d bcd=%h want lat=27 bcd=0001250", lat, bcd);
    end
  endtask

  task automatic test_start();
    int pulses;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL start_busy: got %b want 1", busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) pulses++;
    end
    total++;
    if (pulses != 1 || bcd !== 28'h0001250) begin
      bad++;
      $display("[TB] FAIL start_pulses: got pulses=%0d bcd=%h want pulses=1 bcd=0001250", pulses, bcd);
    end
    temp_data = 25'd777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) pulses++;
    end
    total++;
    if (pulses != 1 || bcd !== 28'h0000777) begin
      bad++;
      $display("[TB] FAIL start_with_change: got pulses=%0d bcd=%h want pulses=1 bcd=0000777", pulses, bcd);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    temp_data = 25'd4321; sign = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bcd, sign_out, ovf, busy, bcd_valid} !== 32'd0) begin
      bad++;
      $display("[TB] FAIL abort_outputs: got bcd=%h s=%b o=%b busy=%b v=%b want all 0",
               bcd, sign_out, ovf, busy, bcd_valid);
    end
    rst_n = 1'b0;
    wait_valid(40, lat);
    total++;
    if (lat != 27 || bcd !== 28'h0004321 || sign_out !== 1'b1 || ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_reconvert: got lat=%0d bcd=%h s=%b o=%b want lat=27 bcd=0004321 s=1 o=0",
               lat, bcd, sign_out, ovf);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_convert(25'd250000, 1'b0, 28'h0250000, 1'b0);
    test_convert(25'd101250, 1'b1, 28'h0101250, 1'b0);
    test_hold_quiet();
    test_convert(25'd10000000, 1'b0, 28'h9999999, 1'b1);
    test_convert(25'd0, 1'b0, 28'h0000000, 1'b0);
    test_convert(25'd9999999, 1'b0, 28'h9999999, 1'b0);
    test_convert(25'd33554431, 1'b0, 28'h9999999, 1'b1);
    test_convert(25'd0, 1'b0, 28'h0000000, 1'b0);
    test_convert(25'd0, 1'b1, 28'h0000000, 1'b0);
    test_convert(25'd1234567, 1'b0, 28'h1234567, 1'b0);
    test_back_to_back();
    test_start();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temp_bcd.md
TEMP_BCD -- requirements
Module: temp_bcd

Interface
REQ-001 SHALL provide parameter: INIT_CONV, default 1, when 1 run one conversion of the current input immediately after reset is released.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-high (the _n suffix is the codebase port name; polarity is fixed as active-high).
REQ-004 SHALL have port: temp_data  input  25  unsigned temperature magnitude in units of 0.0001 degC (raw*625), from ds18b20_ctrl.
REQ-005 SHALL have port: sign  input  1  1 = negative temperature, from ds18b20_ctrl.
REQ-006 SHALL have port: start  input  1  single-cycle request to force a conversion.
REQ-007 SHALL have port: bcd  output  28  seven BCD digits, [27:24] most significant; digits [15:0] are the four fractional digits.
REQ-008 SHALL have port: sign_out  output  1  sign captured with the converted value.
REQ-009 SHALL have port: ovf  output  1  the converted value exceeded 9_999_999.
REQ-010 SHALL have port: busy  output  1  a conversion is in progress.
REQ-011 SHALL have port: bcd_valid  output  1  one-cycle pulse when bcd, sign_out and ovf update.

Function
REQ-012 SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-013 In IDLE: SHALL start a conversion when start=1, or when {sign,temp_data} differs from the snapshot register, or when the INIT_CONV pending flag is set; at that edge (E0) it loads the snapshot from {sign,temp_data}, clears the 28-bit BCD accumulator, and enters SHIFT.
REQ-014 In SHIFT: SHALL perform one double-dabble iteration per cycle, for exactly 25 iterations on edges E1..E25, then enter DONE.
  - Each iteration: add 3 to every accumulator digit >= 5, then shift {accumulator, binary} left by one.
REQ-015 In DONE, at edge E26: SHALL register bcd, sign_out and ovf, assert bcd_valid for exactly one cycle, and return to IDLE.
  - Latency: bcd_valid is high in the 26th cycle after E0.
REQ-016 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-017 If the snapshot temp_data > 9_999_999: SHALL output bcd = 28'h9999999 and ovf = 1; otherwise ovf = 0.
REQ-018 Overflow is determined on the snapshot at E0; the iteration count is unchanged by overflow.
REQ-019 SHALL ignore input changes and start while busy = 1.
  - The snapshot is not reloaded during a conversion, so a change made while busy starts a new conversion on the first IDLE cycle afterwards.
REQ-020 SHALL keep bcd, sign_out and ovf stable between bcd_valid pulses.
REQ-021 When start coincides with a detected change in IDLE: SHALL start exactly one conversion.
REQ-022 SHALL treat sign=1 with temp_data=0 as a change from sign=0 with temp_data=0 and convert it; the output is bcd=0, sign_out=1.
REQ-023 SHALL return to IDLE from any illegal state encoding on the next edge.

Reset
REQ-024 While rst_n = 1 at a clock edge: SHALL set state to IDLE, and clear bcd, sign_out, ovf, busy, bcd_valid, the accumulator and the snapshot to 0.
REQ-025 Reset SHALL set the INIT_CONV pending flag to INIT_CONV; the flag clears at the next conversion start.
REQ-026 Reset asserted mid-conversion: SHALL abort the conversion with no bcd_valid pulse, and the aborted result is never output.

Verification
REQ-027 temp_data=250000, sign=0 (25.0000 degC) -> after 26 cycles: bcd_valid=1, bcd=28'h0250000, sign_out=0, ovf=0.
REQ-028 temp_data=101250, sign=1 (-10.125 degC) -> bcd=28'h0101250, sign_out=1; the input held constant afterwards produces no further bcd_valid.
REQ-029 temp_data=10_000_000 -> bcd=28'h9999999, ovf=1; then temp_data=0 -> bcd=28'h0000000, ovf=0.
REQ-030 Input changed from 625 to 1250 at E5 of a conversion -> the first result is 28'h0000625, followed by a second conversion starting on the first IDLE cycle and giving 28'h0001250.
REQ-031 rst_n pulsed at E10 of a conversion -> no bcd_valid, all outputs 0; with INIT_CONV=1, one conversion of the held input follows the reset release.
REQ-032 start pulsed with an unchanged input, and start pulsed while busy -> exactly one bcd_valid for the idle pulse and none for the busy pulse.
